// File: rtl/acc16_psum_accumulator.sv
// ---------------------------------------------------------------------------
// acc16_psum_accumulator
//
// Purpose:
//   Sits upstream of requantize16_top. Each job covers cfg_entries output
//   entries. For each entry it starts from a per-lane int32 bias, adds
//   cfg_len partial-sum beats lane by lane (32-bit wrap), then hands the
//   final vector to the requantizer with a one-cycle start pulse. Entries
//   use consecutive addresses starting at cfg_addr.
//
// Ports:
//   clk, rst_n          clock; reset is asynchronous and active-HIGH
//                       (asserted while rst_n == 1)
//   cfg_valid/ready     job configuration handshake (ready only in IDLE)
//   cfg_len             partial-sum beats per entry
//   cfg_entries         entries in the job
//   cfg_addr            address of the first entry
//   cfg_bias            per-lane int32 bias, lane k at [k*32+:32]
//   ps_valid/ready      partial-sum beat handshake
//   ps_data             LANES signed int32 partial sums
//   rq_ready            requantizer idle
//   rq_start            one-cycle start pulse to the requantizer
//   rq_addr, rq_acc_vec entry address and accumulated vector
//   ovf_lane            sticky per-lane signed overflow for the current job
//   job_done            one-cycle pulse when the job ends
// ---------------------------------------------------------------------------
module acc16_psum_accumulator #(
    parameter int LANES = 16,
    parameter int AW    = 20,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CW-1:0]         cfg_len,
    input  logic [CW-1:0]         cfg_entries,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [LANES*32-1:0]   cfg_bias,
    input  logic                  ps_valid,
    output logic                  ps_ready,
    input  logic [LANES*32-1:0]   ps_data,
    input  logic                  rq_ready,
    output logic                  rq_start,
    output logic [AW-1:0]         rq_addr,
    output logic [LANES*32-1:0]   rq_acc_vec,
    output logic [LANES-1:0]      ovf_lane,
    output logic                  job_done
);

    localparam int VW = LANES * 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    entries_q;
    logic [AW-1:0]    addr_q;
    logic [VW-1:0]    bias_q;
    logic [VW-1:0]    acc_q;
    logic [LANES-1:0] ovf_q;
    logic [CW-1:0]    beat_cnt;
    logic [CW-1:0]    ent_cnt;
    // Snapshot of the last issued entry, so the requantizer may sample the
    // vector and address on or after the start cycle while acc_q is already
    // being rebuilt for the next entry.
    logic [VW-1:0]    hold_vec_q;
    logic [AW-1:0]    hold_addr_q;

    logic [VW-1:0]    sum_vec;
    logic [LANES-1:0] beat_ovf;
    logic             beat_fire;
    logic             last_beat;
    logic             last_entry;

    // Lane-wise wrap-around add of the incoming beat, with signed overflow:
    // operands share a sign and the result sign differs.
    // NOTE: every signal written in a combinational block gets a default at
    // the top so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        sum_vec  = '0;
        beat_ovf = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_vec[k*32 +: 32] = acc_q[k*32 +: 32] + ps_data[k*32 +: 32];
            beat_ovf[k] = (acc_q[k*32+31] == ps_data[k*32+31]) &&
                          (sum_vec[k*32+31] != acc_q[k*32+31]);
        end
    end

    assign beat_fire  = ps_valid && (state == S_ACCUM);
    assign last_beat  = (beat_cnt == len_q - CW'(1));
    assign last_entry = (ent_cnt == entries_q - CW'(1));

    assign cfg_ready  = (state == S_IDLE);
    assign ps_ready   = (state == S_ACCUM);
    assign rq_start   = (state == S_ISSUE) && rq_ready;
    assign job_done   = (state == S_DONE);
    assign ovf_lane   = ovf_q;
    // Live accumulator while issuing; the captured copy afterwards.
    assign rq_acc_vec = (state == S_ISSUE) ? acc_q  : hold_vec_q;
    assign rq_addr    = (state == S_ISSUE) ? addr_q : hold_addr_q;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: the wide accumulator/bias registers are cleared too; a
            // reset mid-job must leave nothing of the aborted job visible.
            state       <= S_IDLE;
            len_q       <= '0;
            entries_q   <= '0;
            addr_q      <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
            beat_cnt    <= '0;
            ent_cnt     <= '0;
            hold_vec_q  <= '0;
            hold_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        len_q     <= cfg_len;
                        entries_q <= cfg_entries;
                        addr_q    <= cfg_addr;
                        bias_q    <= cfg_bias;
                        acc_q     <= cfg_bias;
                        ovf_q     <= '0;
                        beat_cnt  <= '0;
                        ent_cnt   <= '0;
                        if (cfg_entries == '0)
                            state <= S_DONE;
                        else if (cfg_len == '0)
                            state <= S_ISSUE;
                        else
                            state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (beat_fire) begin
                        acc_q    <= sum_vec;
                        ovf_q    <= ovf_q | beat_ovf;
                        beat_cnt <= beat_cnt + CW'(1);
                        if (last_beat)
                            state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // rq_start is high exactly in this branch, so each entry
                    // gets one start and leaves ISSUE (or moves to the next
                    // entry when len is zero) on the same edge.
                    if (rq_ready) begin
                        hold_vec_q  <= acc_q;
                        hold_addr_q <= addr_q;
                        ent_cnt     <= ent_cnt + CW'(1);
                        if (last_entry) begin
                            state <= S_DONE;
                        end else begin
                            addr_q   <= addr_q + AW'(1);
                            acc_q    <= bias_q;
                            beat_cnt <= '0;
                            state    <= (len_q == '0) ? S_ISSUE : S_ACCUM;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc16_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_acc16_psum_accumulator
//
// Scoreboard bench: each job is evaluated up front by a plain-arithmetic
// reference model that pushes the expected (address, vector) of every entry
// into queues; a separate monitor pops and compares whenever rq_start fires.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_acc16_psum_accumulator;

    localparam int LANES = 16;
    localparam int AW    = 20;
    localparam int CW    = 16;
    localparam int VW    = LANES * 32;

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_len;
    logic [CW-1:0]   cfg_entries;
    logic [AW-1:0]   cfg_addr;
    logic [VW-1:0]   cfg_bias;
    logic            ps_valid;
    logic            ps_ready;
    logic [VW-1:0]   ps_data;
    logic            rq_ready;
    logic            rq_start;
    logic [AW-1:0]   rq_addr;
    logic [VW-1:0]   rq_acc_vec;
    logic [LANES-1:0] ovf_lane;
    logic            job_done;

    acc16_psum_accumulator #(.LANES(LANES), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_len    (cfg_len),
        .cfg_entries(cfg_entries),
        .cfg_addr   (cfg_addr),
        .cfg_bias   (cfg_bias),
        .ps_valid   (ps_valid),
        .ps_ready   (ps_ready),
        .ps_data    (ps_data),
        .rq_ready   (rq_ready),
        .rq_start   (rq_start),
        .rq_addr    (rq_addr),
        .rq_acc_vec (rq_acc_vec),
        .ovf_lane   (ovf_lane),
        .job_done   (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard state
    logic [VW-1:0] beats[$];
    logic [AW-1:0] exp_addr[$];
    logic [VW-1:0] exp_vec[$];
    logic [VW-1:0] last_vec;
    logic [AW-1:0] last_addr;
    int            last_start_cyc = -10;

    function automatic logic [VW-1:0] splat(input logic [31:0] v);
        logic [VW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    // Reference add: exact integer sum, then wrap; overflow means the exact
    // sum does not fit in int32.
    function automatic void lane_add(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] s, output bit ovf);
        longint exact;
        exact = longint'($signed(a)) + longint'($signed(b));
        s     = exact[31:0];
        ovf   = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    endfunction

    // Monitor: every start must be expected, with rq_ready high.
    always @(negedge clk) begin
        if (rq_start) begin
            check("start_while_ready", rq_ready, 1'b1);
            check("start_expected", exp_addr.size() != 0, 1'b1);
            if (exp_addr.size() != 0) begin
                check("rq_addr", rq_addr, exp_addr.pop_front());
                check("rq_acc_vec", rq_acc_vec, exp_vec.pop_front());
            end
            last_start_cyc = cyc;
        end
    end

    // One complete job. Beats come from the global 'beats' queue (len*ent of
    // them). pvalid: percent chance of ps_valid per cycle. rq_rand: random
    // rq_ready. hold: for a single-entry job, cycles rq_ready stays low after
    // the last beat.
    task automatic run_job(input int len, input int ent, input logic [AW-1:0] addr,
                           input logic [VW-1:0] bias, input int pvalid,
                           input bit rq_rand, input int hold);
        logic [LANES-1:0] exp_ovf;
        logic [AW-1:0]    a;
        logic [VW-1:0]    v;
        logic [VW-1:0]    bt;
        logic [31:0]      s;
        bit               o;
        int               nbeats;
        int               bi;
        int               guard;
        int               t_cfg;
        int               wait_cyc;
        bit               done;
        bit               first;
        bit               in_wait;

        // Reference model
        exp_ovf = '0;
        a       = addr;
        nbeats  = len * ent;
        for (int e = 0; e < ent; e++) begin
            v = bias;
            for (int b = 0; b < len; b++) begin
                bt = beats[e*len + b];
                for (int k = 0; k < LANES; k++) begin
                    lane_add(v[k*32 +: 32], bt[k*32 +: 32], s, o);
                    v[k*32 +: 32] = s;
                    if (o) exp_ovf[k] = 1'b1;
                end
            end
            exp_addr.push_back(a);
            exp_vec.push_back(v);
            last_vec  = v;
            last_addr = a;
            a = a + AW'(1);
        end

        // Configuration handshake
        @(posedge clk); #1;
        cfg_valid   = 1'b1;
        cfg_len     = CW'(len);
        cfg_entries = CW'(ent);
        cfg_addr    = addr;
        cfg_bias    = bias;
        @(negedge clk);
        check("cfg_ready_idle", cfg_ready, 1'b1);
        t_cfg = cyc;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_bias  = '0;

        bi = 0; guard = 0; done = 0; first = 1; wait_cyc = 0;
        while (!done && guard < 5000) begin
            in_wait = (hold > 0) && (bi == nbeats);
            if (in_wait)      rq_ready = (wait_cyc >= hold);
            else if (rq_rand) rq_ready = 1'($urandom_range(1));
            else              rq_ready = 1'b1;
            ps_valid = (bi < nbeats) && ($urandom_range(99) < pvalid);
            ps_data  = (bi < nbeats) ? beats[bi] : {LANES{$urandom()}};
            @(negedge clk);
            if (first && len > 0 && ent > 0) check("ps_ready_latency", ps_ready, 1'b1);
            first = 0;
            check("cfg_ready_busy", cfg_ready, 1'b0);
            if (len == 0) check("ps_ready_len0", ps_ready, 1'b0);
            if (in_wait && wait_cyc < hold) begin
                check("wait_ps_ready", ps_ready, 1'b0);
                check("wait_no_start", rq_start, 1'b0);
                check("wait_vec_stable", rq_acc_vec, last_vec);
            end else if (in_wait && wait_cyc == hold) begin
                check("start_on_ready", rq_start, 1'b1);
            end
            if (in_wait) wait_cyc++;
            if (ps_valid && ps_ready) bi++;
            if (job_done) begin
                done = 1;
                if (ent == 0) check("done_latency", cyc, t_cfg + 1);
                else          check("done_latency", cyc, last_start_cyc + 1);
            end
            guard++;
            @(posedge clk); #1;
        end
        ps_valid = 1'b0;
        rq_ready = 1'b1;
        check("job_finished", done, 1'b1);
        check("beat_count", bi, nbeats);
        check("all_entries_issued", exp_addr.size(), 0);
        exp_addr.delete();
        exp_vec.delete();
        // Back in IDLE: overflow flags and last issued entry still held.
        check("ovf_lane", ovf_lane, exp_ovf);
        check("cfg_ready_after", cfg_ready, 1'b1);
        if (ent > 0) begin
            check("hold_addr", rq_addr, last_addr);
            check("hold_vec", rq_acc_vec, last_vec);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] bias_v;
        logic [VW-1:0] beat_v;
        rst_n = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_entries = '0; cfg_addr = '0;
        cfg_bias = '0; ps_valid = 1'b0; ps_data = '0; rq_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_ps_ready", ps_ready, 1'b0);
        check("rst_rq_start", rq_start, 1'b0);
        check("rst_job_done", job_done, 1'b0);
        check("rst_ovf", ovf_lane, '0);
        check("rst_rq_addr", rq_addr, '0);
        check("rst_rq_vec", rq_acc_vec, '0);
        rst_n = 1'b0;

        // 1. Basic job
        beats.delete();
        beats.push_back(splat(1));  beats.push_back(splat(2));  beats.push_back(splat(3));
        beats.push_back(splat(10)); beats.push_back(splat(20)); beats.push_back(splat(30));
        run_job(3, 2, 20'd5, splat(100), 100, 0, 0);
        check("basic_addr_const", rq_addr, 20'd6);
        check("basic_vec_const", rq_acc_vec, splat(160));

        // 2. Requantizer backpressure
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back({LANES{$urandom()}});
        run_job(4, 1, 20'd40, splat(32'hFFFF_FF00), 100, 0, 7);

        // 3. Overflow and wrap
        bias_v = splat(16);
        bias_v[3*32 +: 32] = 32'h7FFF_FFF0;
        bias_v[9*32 +: 32] = 32'h8000_0000;
        beat_v = splat(1);
        beat_v[3*32 +: 32] = 32'h0000_0020;
        beat_v[9*32 +: 32] = 32'hFFFF_FFFF;
        beats.delete();
        beats.push_back(beat_v);
        run_job(1, 1, 20'd77, bias_v, 100, 0, 0);
        check("ovf_const", ovf_lane, 16'h0208);
        check("lane3_wrap", rq_acc_vec[3*32 +: 32], 32'h8000_0010);
        check("lane9_wrap", rq_acc_vec[9*32 +: 32], 32'h7FFF_FFFF);
        check("lane0_plain", rq_acc_vec[31:0], 32'd17);

        // 4. Degenerate configurations
        beats.delete();
        run_job(0, 3, 20'd100, splat(-32'sd7), 100, 0, 0);
        check("len0_last_addr", rq_addr, 20'd102);
        check("len0_vec", rq_acc_vec, splat(32'hFFFF_FFF9));
        run_job(3, 0, 20'd200, splat(1), 100, 0, 0);

        // 5. Input stalls with random signed data and random rq_ready
        for (int j = 0; j < 2; j++) begin
            beats.delete();
            for (int i = 0; i < 16 * 4; i++) begin
                for (int k = 0; k < LANES; k++) beat_v[k*32 +: 32] = $urandom();
                beats.push_back(beat_v);
            end
            for (int k = 0; k < LANES; k++) bias_v[k*32 +: 32] = $urandom();
            run_job(16, 4, AW'($urandom()), bias_v, 30, 1, 0);
        end

        // 6a. Reset mid-ACCUM
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_len = 16'd4; cfg_entries = 16'd2; cfg_addr = 20'd7;
        cfg_bias = splat(5);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_bias = '0;
        ps_valid = 1'b1; ps_data = splat(1);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b1;
        #1;
        check("midrst_cfg_ready", cfg_ready, 1'b1);
        check("midrst_ps_ready", ps_ready, 1'b0);
        check("midrst_rq_start", rq_start, 1'b0);
        check("midrst_job_done", job_done, 1'b0);
        check("midrst_ovf", ovf_lane, '0);
        check("midrst_rq_addr", rq_addr, '0);
        check("midrst_rq_vec", rq_acc_vec, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("postrst_cfg_ready", cfg_ready, 1'b1);
            check("postrst_ps_ready", ps_ready, 1'b0);
            check("postrst_no_done", job_done, 1'b0);
        end
        @(posedge clk); #1;
        ps_valid = 1'b0;

        // 6b. Address wrap
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back({LANES{$urandom()}});
        run_job(2, 2, 20'hFFFFF, splat(3), 100, 0, 0);
        check("addr_wrap_const", rq_addr, 20'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
